// File: rtl/adt7420_i2c_reader.sv
// ADT7420 temperature read master: START, address+R, MSB, LSB, STOP with 4 clocks per SCL bit.
// Optional macro ADT7420_ACK_CHECK_EN aborts to STOP on an address NACK and raises ack_error.
module adt7420_i2c_reader #(
  parameter logic [6:0] DEV_ADDR = 7'h4B
) (
  input  logic        clk_200kHz,
  input  logic        reset,
  input  logic        start,
  input  logic        sda_in,
  output logic        scl,
  output logic        sda_oe,
  output logic        busy,
  output logic [15:0] temp_data,
  output logic        data_valid,
  output logic        ack_error
);
  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_RD_MSB, S_M_ACK, S_RD_LSB, S_M_NACK, S_STOP
  } state_t;

  localparam logic [7:0] ADDR_BYTE = {DEV_ADDR, 1'b1};

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [2:0]  bit_q, bit_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] temp_q;
  logic        scl_q, scl_d, sda_oe_q, sda_oe_d, busy_q, valid_q;
  logic        bit_end, accept, done;

`ifdef ADT7420_ACK_CHECK_EN
  logic nack_q, nack_d, ack_err_q, ack_err_d;
`endif

  assign bit_end = (phase_q == 2'd3);
  // A request arriving on the final STOP cycle chains straight into a new START.
  assign accept  = start && ((state_q == S_IDLE) || (state_q == S_STOP && bit_end));

`ifdef ADT7420_ACK_CHECK_EN
  assign done = (state_q == S_STOP) && bit_end && !nack_q;

  always_comb begin
    nack_d    = nack_q;
    ack_err_d = ack_err_q;
    if (state_q == S_ADDR_ACK && phase_q == 2'd2) nack_d = sda_in;
    if (state_q == S_ADDR_ACK && bit_end && nack_q) ack_err_d = 1'b1;
    if (accept) begin
      nack_d    = 1'b0;
      ack_err_d = 1'b0;
    end
  end
`else
  assign done = (state_q == S_STOP) && bit_end;
`endif

  always_comb begin
    state_d = state_q;
    phase_d = (state_q == S_IDLE) ? 2'd0 : phase_q + 2'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    if ((state_q == S_RD_MSB || state_q == S_RD_LSB) && phase_q == 2'd2)
      shift_d = {shift_q[14:0], sda_in};
    if (bit_end) begin
      case (state_q)
        S_START: state_d = S_ADDR;
        S_ADDR: begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_ADDR_ACK;
        end
`ifdef ADT7420_ACK_CHECK_EN
        S_ADDR_ACK: state_d = nack_q ? S_STOP : S_RD_MSB;
`else
        S_ADDR_ACK: state_d = S_RD_MSB;
`endif
        S_RD_MSB: begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_M_ACK;
        end
        S_M_ACK: state_d = S_RD_LSB;
        S_RD_LSB: begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_M_NACK;
        end
        S_M_NACK: state_d = S_STOP;
        S_STOP:   state_d = S_IDLE;
        default:  state_d = state_q;
      endcase
    end
    if (accept) begin
      state_d = S_START;
      phase_d = 2'd0;
      bit_d   = 3'd0;
    end
  end

  // Bus levels are decoded from the next state so the pins are registered yet line up with it.
  always_comb begin
    scl_d    = phase_d[1];
    sda_oe_d = 1'b0;
    case (state_d)
      S_IDLE:  scl_d = 1'b1;
      S_START: begin
        scl_d    = 1'b1;
        sda_oe_d = phase_d[1];
      end
      S_ADDR:  sda_oe_d = ~ADDR_BYTE[3'd7 - bit_d];
      S_M_ACK: sda_oe_d = 1'b1;
      S_STOP: begin
        scl_d    = (phase_d != 2'd0);
        sda_oe_d = ~phase_d[1];
      end
      default: sda_oe_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_200kHz) begin
    if (reset) begin
      state_q   <= S_IDLE;
      phase_q   <= 2'd0;
      bit_q     <= 3'd0;
      shift_q   <= 16'h0000;
      temp_q    <= 16'h0000;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
`ifdef ADT7420_ACK_CHECK_EN
      nack_q    <= 1'b0;
      ack_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= (state_d != S_IDLE);
      valid_q   <= done;
      if (done) temp_q <= shift_q;
`ifdef ADT7420_ACK_CHECK_EN
      nack_q    <= nack_d;
      ack_err_q <= ack_err_d;
`endif
    end
  end

  assign scl        = scl_q;
  assign sda_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign temp_data  = temp_q;
  assign data_valid = valid_q;
`ifdef ADT7420_ACK_CHECK_EN
  assign ack_error  = ack_err_q;
`else
  assign ack_error  = 1'b0;
`endif

endmodule

// File: tb/tb_adt7420_i2c_reader.sv
// Bench for adt7420_i2c_reader: bus-level slave model, protocol monitor and random read data.
`timescale 1ns/1ps
module tb_adt7420_i2c_reader;
`ifdef ADT7420_ACK_CHECK_EN
  localparam bit ACK_CHK = 1'b1;
`else
  localparam bit ACK_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sda_in;
  logic        scl, sda_oe, busy, data_valid, ack_error;
  logic [15:0] temp_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t0 = 0;
  logic [15:0] model_temp = 16'h0000;

  // Slave model state
  logic [7:0] slv_msb = 8'h00, slv_lsb = 8'h00;
  bit         slv_ack = 1'b1;
  logic       slv_drive = 1'b0;
  int         bitno = 0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  int         rise_q[$], start_q[$], stop_q[$];
  logic       rx_q[$];

  always #2500 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sda_in = ~(sda_oe | slv_drive);

  adt7420_i2c_reader #(.DEV_ADDR(7'h4B)) dut (
    .clk_200kHz(clk), .reset(reset), .start(start), .sda_in(sda_in),
    .scl(scl), .sda_oe(sda_oe), .busy(busy), .temp_data(temp_data),
    .data_valid(data_valid), .ack_error(ack_error)
  );

  // Open-drain slave: watches START/STOP/SCL edges and drives its bits while SCL is low.
  always @(negedge clk) begin
    logic bus_now;
    bus_now = ~(sda_oe | slv_drive);
    if (reset) begin
      slv_drive = 1'b0;
      bitno = 0;
    end else begin
      if (prev_scl && scl && prev_sda && !bus_now) begin
        start_q.push_back(cyc - t0);
        bitno = 0;
        rx_q.delete();
      end
      if (prev_scl && scl && !prev_sda && bus_now) stop_q.push_back(cyc - t0);
      if (!prev_scl && scl) begin
        rise_q.push_back(cyc - t0);
        rx_q.push_back(bus_now);
        bitno++;
      end
      if (prev_scl && !scl) begin
        if (bitno == 8)                      slv_drive = slv_ack;
        else if (bitno >= 9 && bitno <= 16)  slv_drive = slv_ack && !slv_msb[16 - bitno];
        else if (bitno >= 18 && bitno <= 25) slv_drive = slv_ack && !slv_lsb[25 - bitno];
        else                                 slv_drive = 1'b0;
      end
    end
    prev_scl = scl;
    prev_sda = ~(sda_oe | slv_drive);
  end

  task automatic do_read(input logic [7:0] m, input logic [7:0] l, input bit ack,
                         input int pa, input int pb);
    int exp_len, nbits, done_c, valid_c, valid_n, exp_vc, rbad, st, sp;
    bit full;
    logic [15:0] exp_temp;
    logic exp_err;
    logic [7:0] addr_rx;
    full     = ack || !ACK_CHK;
    nbits    = full ? 27 : 9;
    exp_len  = full ? 116 : 44;
    exp_temp = !full ? model_temp : (ack ? {m, l} : 16'hFFFF);
    exp_err  = ACK_CHK && !ack;
    exp_vc   = full ? exp_len : -1;
    slv_msb = m; slv_lsb = l; slv_ack = ack;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc + 1;
    rise_q.delete(); start_q.delete(); stop_q.delete();
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if ({busy, ack_error} !== 2'b10) begin
      miscompares++;
      $display("FAIL accept: busy,ack_error got %b want 10", {busy, ack_error});
    end
    done_c = -1; valid_c = -1; valid_n = 0;
    for (int c = 1; c <= 200 && done_c < 0; c++) begin
      @(negedge clk);
      start = (c == pa || c == pb);
      if (data_valid === 1'b1) begin valid_n++; valid_c = c; end
      if (busy === 1'b0) done_c = c;
    end
    start = 1'b0;
    vectors++;
    if (done_c !== exp_len) begin
      miscompares++;
      $display("FAIL busy_len: got %0d cycles want %0d", done_c, exp_len);
    end
    vectors++;
    if (valid_c !== exp_vc || valid_n !== (full ? 1 : 0)) begin
      miscompares++;
      $display("FAIL valid_pulse: got cycle %0d count %0d want cycle %0d", valid_c, valid_n, exp_vc);
    end
    vectors++;
    if (temp_data !== exp_temp) begin
      miscompares++;
      $display("FAIL temp_data: got %h want %h", temp_data, exp_temp);
    end
    vectors++;
    if (ack_error !== exp_err) begin
      miscompares++;
      $display("FAIL ack_error: got %b want %b", ack_error, exp_err);
    end
    model_temp = exp_temp;
    st = (start_q.size() == 1) ? start_q[0] : -1;
    sp = (stop_q.size() == 1) ? stop_q[0] : -1;
    vectors++;
    if (st !== 2 || sp !== 4 + 4 * nbits + 2) begin
      miscompares++;
      $display("FAIL start_stop: got %0d/%0d want 2/%0d", st, sp, 4 + 4 * nbits + 2);
    end
    rbad = (rise_q.size() == nbits + 1) ? 0 : 1000;
    for (int k = 0; k < rise_q.size() && k < nbits; k++)
      if (rise_q[k] != 6 + 4 * k) rbad++;
    if (rise_q.size() == nbits + 1 && rise_q[nbits] != 4 + 4 * nbits + 1) rbad++;
    vectors++;
    if (rbad !== 0) begin
      miscompares++;
      $display("FAIL scl_frame: got %0d bad rises (of %0d) want 0", rbad, rise_q.size());
    end
    addr_rx = 8'h00;
    for (int k = 0; k < 8 && k < rx_q.size(); k++) addr_rx = {addr_rx[6:0], rx_q[k]};
    vectors++;
    if (addr_rx !== 8'h97) begin
      miscompares++;
      $display("FAIL addr_byte: got %h want 97", addr_rx);
    end
    if (full) begin
      vectors++;
      if (rx_q.size() < 27 || rx_q[17] !== 1'b0 || rx_q[26] !== 1'b1) begin
        miscompares++;
        $display("FAIL master_ack_nack: got %0d bits want ACK=0 at 17, NACK=1 at 26", rx_q.size());
      end
    end
    @(negedge clk);
    vectors++;
    if ({data_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL after_done: data_valid,busy got %b want 00", {data_valid, busy});
    end
  endtask

  task automatic test_reset();
    int dv;
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    dv = 0;
    repeat (10) begin
      @(negedge clk);
      if (data_valid === 1'b1) dv++;
    end
    vectors++;
    if ({scl, sda_oe, busy, ack_error} !== 4'b1000 || temp_data !== 16'h0000 || dv !== 0) begin
      miscompares++;
      $display("FAIL reset_idle: scl,oe,busy,err got %b temp %h dv %0d want 1000 0000 0",
               {scl, sda_oe, busy, ack_error}, temp_data, dv);
    end
    model_temp = 16'h0000;
  endtask

  task automatic test_read();
    do_read(8'h0C, 8'h80, 1'b1, -1, -1);
    repeat (4) do_read(8'($urandom), 8'($urandom), 1'b1, -1, -1);
  endtask

  task automatic test_nack();
    do_read(8'($urandom), 8'($urandom), 1'b0, -1, -1);
    do_read(8'($urandom), 8'($urandom), 1'b1, -1, -1);
  endtask

  task automatic test_ignore_start();
    do_read(8'($urandom), 8'($urandom), 1'b1, 5, 60);
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    int early;
    slv_ack = 1'b1;
    slv_msb = 8'($urandom); slv_lsb = 8'($urandom);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      exp = {slv_msb, slv_lsb};
      early = 0;
      for (int c = 1; c <= 116; c++) begin
        @(negedge clk);
        if (i == 2 && c == 115) start = 1'b0;
        if (c < 116 && data_valid === 1'b1) early++;
      end
      vectors++;
      if (data_valid !== 1'b1 || early !== 0 || temp_data !== exp || busy !== (i < 2)) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: dv %b early %0d temp %h busy %b want 1 0 %h %b",
                 i, data_valid, early, temp_data, busy, exp, (i < 2));
      end
      model_temp = exp;
      slv_msb = 8'($urandom); slv_lsb = 8'($urandom);
    end
  endtask

  task automatic test_reset_mid();
    slv_ack = 1'b1;
    slv_msb = 8'($urandom); slv_lsb = 8'($urandom);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({scl, sda_oe, busy} !== 3'b100 || temp_data !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_mid: scl,oe,busy got %b temp %h want 100 0000", {scl, sda_oe, busy}, temp_data);
    end
    model_temp = 16'h0000;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    do_read(8'($urandom), 8'($urandom), 1'b1, -1, -1);
  endtask

  initial begin
    test_reset();
    test_read();
    test_nack();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
